har_tnn1_tnnzeq: RTL and testbench
==================================

Name: har_tnn1_tnnzeq

Overview:
Sequential ternary neural network classifier for the HAR (human activity recognition) dataset.
- Takes 12 unsigned 4-bit features.
- Layer 1: 40 ternary-weight neurons, one feature per cycle; each neuron outputs a binary "sum >= 0" activation.
- Layer 2: 6 ternary-weight class scores, one hidden bit per cycle; outputs the argmax class index.
- Standalone inference core; started by releasing reset, result held until the next reset.

Parameters:
- FEAT_CNT, 12, number of input features.
- HIDDEN_CNT, 40, number of hidden neurons.
- FEAT_BITS, 4, bits per feature, unsigned.
- CLASS_CNT, 6, number of output classes.
- HIDDEN_W, all zeros, 2*FEAT_CNT*HIDDEN_CNT-bit packed layer-1 weights. Weight (neuron j, feature i) is at bits [2*(j*FEAT_CNT+i) +: 2].
- OUT_W, all zeros, 2*HIDDEN_CNT*CLASS_CNT-bit packed layer-2 weights. Weight (class k, hidden j) is at bits [2*(k*HIDDEN_CNT+j) +: 2].
- Weight code for both arrays: 2'b01 = +1, 2'b11 = -1, 2'b00 or 2'b10 = 0.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-low reset.
- data, input, FEAT_BITS*FEAT_CNT, feature vector; feature i is data[FEAT_BITS*i +: FEAT_BITS]. Must be held stable from reset release until the result is ready.
- prediction, output, $clog2(CLASS_CNT), winning class index.

Behaviour:
Reset (rst low, async):
- Phase goes to L1; feature counter = 0; hidden counter = 0.
- All hidden accumulators = 0; all class scores = 0; hidden bit vector = 0.
- prediction = 0.

Phase L1 (FEAT_CNT cycles, feature counter f = 0..FEAT_CNT-1):
- Each cycle, every neuron j does acc_j += w1(j,f) * data feature f. Multiply is add, subtract or hold.
- acc_j is signed, width $clog2(FEAT_CNT*(2^FEAT_BITS-1)+1)+1, which is 9 bits at defaults. No overflow is possible.
- On the edge where f = FEAT_CNT-1: set hidden_j = (acc_j + final term >= 0). A zero sum gives 1.
- Same edge: enter L2 with hidden counter = 0.

Phase L2 (HIDDEN_CNT cycles, hidden counter h = 0..HIDDEN_CNT-1):
- Each cycle, for every class k: if hidden_h = 1 then score_k += w2(k,h); otherwise no change.
- score_k is signed, width $clog2(HIDDEN_CNT+1)+1, which is 7 bits at defaults.
- On the edge where h = HIDDEN_CNT-1: enter DONE.
- Same edge: register prediction = argmax_k of the final scores (including the last term).

Argmax rule:
- Signed compare.
- Ties resolve to the lowest class index.

DONE:
- All state frozen.
- prediction held until the next reset.
- data ignored.

Latency:
- prediction is valid after exactly FEAT_CNT+HIDDEN_CNT rising edges following reset release (52 at defaults).
- Before that point prediction reads 0.

Reset mid-operation:
- Aborts the inference immediately and returns to the reset state.
- A new inference begins on release.

Changing data:
- A change during L1 affects only the terms of features not yet consumed. This is undefined use but must not hang the core.

Optional Feature:
Macro: TNN_VALID_EN
- Defined: adds output port valid (1 bit).
  - valid = 0 on reset.
  - valid goes to 1 on the same edge that registers prediction and stays 1 in DONE.
  - valid clears on reset.
- Undefined: no valid port; otherwise identical behaviour.

Test Plan:
- Default parameters (all weights 0), any data, release reset, wait 52 edges → all hidden = 1, all scores 0, prediction = 0 (tie goes to lowest index).
- HIDDEN_W all 2'b11 (-1); OUT_W class 5 all +1, others 0; data all 4'h0 → every sum is 0, so hidden all 1; score5 = 40; prediction = 5.
- Same weights, data all 4'h1 → sums = -12, hidden all 0, scores all 0; prediction = 0.
- HIDDEN_W all +1, data all 4'hF; OUT_W class 2 all +1 and class 4 all +1 → tie at 40, prediction = 2. Also check that prediction reads 0 at edge 51 and 2 at edge 52.
- Run the case above, assert rst low at edge 30, then release → prediction = 0 until 52 edges after the new release, then 2.
- With TNN_VALID_EN: valid = 0 through edge 51, = 1 from edge 52, = 0 immediately on async reset assertion between clock edges.

Source files
------------

// File: rtl/har_tnn1_tnnzeq.sv
// Sequential ternary neural network classifier (12 features -> 40 hidden -> 6 classes).
// Optional macro TNN_VALID_EN adds a 'valid' output that rises with the registered prediction.
module har_tnn1_tnnzeq #(
  parameter int FEAT_CNT   = 12,
  parameter int HIDDEN_CNT = 40,
  parameter int FEAT_BITS  = 4,
  parameter int CLASS_CNT  = 6,
  parameter logic [2*FEAT_CNT*HIDDEN_CNT-1:0]  HIDDEN_W = '0,
  parameter logic [2*HIDDEN_CNT*CLASS_CNT-1:0] OUT_W    = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [FEAT_BITS*FEAT_CNT-1:0]   data,
  output logic [$clog2(CLASS_CNT)-1:0]    prediction
`ifdef TNN_VALID_EN
  ,
  output logic                            valid
`endif
);

  localparam int ACC_W   = $clog2(FEAT_CNT*(2**FEAT_BITS-1)+1) + 1;
  localparam int SCORE_W = $clog2(HIDDEN_CNT+1) + 1;
  localparam int PRED_W  = $clog2(CLASS_CNT);
  localparam int FC_W    = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam int HC_W    = (HIDDEN_CNT > 1) ? $clog2(HIDDEN_CNT) : 1;

  typedef enum logic [1:0] {
    PH_L1,
    PH_L2,
    PH_DONE
  } phase_e;

  phase_e                    r_phase;
  phase_e                    w_phase_nxt;
  logic [FC_W-1:0]           r_feat_cnt;
  logic [HC_W-1:0]           r_hid_cnt;
  logic signed [ACC_W-1:0]   r_acc       [HIDDEN_CNT];
  logic signed [ACC_W-1:0]   w_acc_nxt   [HIDDEN_CNT];
  logic [HIDDEN_CNT-1:0]     r_hidden;
  logic signed [SCORE_W-1:0] r_score     [CLASS_CNT];
  logic signed [SCORE_W-1:0] w_score_nxt [CLASS_CNT];
  logic [PRED_W-1:0]         r_pred;
  logic [PRED_W-1:0]         w_argmax;
  logic [FEAT_BITS-1:0]      w_feat;
  logic                      w_hbit;
  logic                      w_l1_last;
  logic                      w_l2_last;
  int                        w_fi;
  int                        w_hi;

  function automatic logic signed [ACC_W-1:0] l1_term(input logic [1:0] w,
                                                       input logic [FEAT_BITS-1:0] x);
    logic signed [ACC_W-1:0] xe;
    xe = ACC_W'(x);
    case (w)
      2'b01:   return xe;
      2'b11:   return -xe;
      default: return '0;
    endcase
  endfunction

  function automatic logic signed [SCORE_W-1:0] l2_term(input logic [1:0] w);
    case (w)
      2'b01:   return SCORE_W'(1);
      2'b11:   return '1;
      default: return '0;
    endcase
  endfunction

  assign w_fi      = int'(r_feat_cnt);
  assign w_hi      = int'(r_hid_cnt);
  assign w_feat    = data[FEAT_BITS*w_fi +: FEAT_BITS];
  assign w_hbit    = r_hidden[w_hi];
  assign w_l1_last = (r_phase == PH_L1) && (r_feat_cnt == FC_W'(FEAT_CNT-1));
  assign w_l2_last = (r_phase == PH_L2) && (r_hid_cnt == HC_W'(HIDDEN_CNT-1));

  always_comb begin
    for (int j = 0; j < HIDDEN_CNT; j++)
      w_acc_nxt[j] = r_acc[j] + l1_term(HIDDEN_W[2*(j*FEAT_CNT+w_fi) +: 2], w_feat);
  end

  always_comb begin
    for (int k = 0; k < CLASS_CNT; k++)
      w_score_nxt[k] = r_score[k] +
                       (w_hbit ? l2_term(OUT_W[2*(k*HIDDEN_CNT+w_hi) +: 2]) : '0);
  end

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    w_argmax = '0;
    for (int k = 1; k < CLASS_CNT; k++)
      if (w_score_nxt[k] > w_score_nxt[w_argmax]) w_argmax = PRED_W'(k);
  end

  // NOTE: combinational blocks assign every output a default first so no latch is inferred.
  always_comb begin
    w_phase_nxt = r_phase;
    case (r_phase)
      PH_L1:   if (w_l1_last) w_phase_nxt = PH_L2;
      PH_L2:   if (w_l2_last) w_phase_nxt = PH_DONE;
      default: w_phase_nxt = r_phase;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_phase <= PH_L1;
    else      r_phase <= w_phase_nxt;
  end

  // NOTE: accumulator and score arrays are reset because every inference starts from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_feat_cnt <= '0;
      r_hid_cnt  <= '0;
      r_hidden   <= '0;
      r_pred     <= '0;
      for (int j = 0; j < HIDDEN_CNT; j++) r_acc[j] <= '0;
      for (int k = 0; k < CLASS_CNT; k++) r_score[k] <= '0;
    end else begin
      case (r_phase)
        PH_L1: begin
          for (int j = 0; j < HIDDEN_CNT; j++) r_acc[j] <= w_acc_nxt[j];
          if (w_l1_last) begin
            r_feat_cnt <= '0;
            r_hid_cnt  <= '0;
            for (int j = 0; j < HIDDEN_CNT; j++) r_hidden[j] <= ~w_acc_nxt[j][ACC_W-1];
          end else begin
            r_feat_cnt <= r_feat_cnt + FC_W'(1);
          end
        end
        PH_L2: begin
          for (int k = 0; k < CLASS_CNT; k++) r_score[k] <= w_score_nxt[k];
          if (w_l2_last) r_pred    <= w_argmax;
          else           r_hid_cnt <= r_hid_cnt + HC_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign prediction = r_pred;

`ifdef TNN_VALID_EN
  logic r_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_valid <= 1'b0;
    else if (w_l2_last) r_valid <= 1'b1;
  end

  assign valid = r_valid;
`endif

endmodule

// File: tb/tb_har_tnn1_tnnzeq.sv
// Self-checking bench for har_tnn1_tnnzeq: four weight sets checked every cycle against
// a plain-arithmetic reference model, plus hand-computed literal expectations.
module tb_har_tnn1_tnnzeq;

  localparam int LAT = 52;

  localparam logic [959:0] HW_B = {960{1'b1}};
  localparam logic [479:0] OW_B = {{40{2'b01}}, 400'b0};
  localparam logic [959:0] HW_C = {480{2'b01}};
  localparam logic [479:0] OW_C = {80'b0, {40{2'b01}}, 80'b0, {40{2'b01}}, 160'b0};
  localparam logic [959:0] HW_D = {{68{14'b01_11_00_01_01_11_10}}, 8'b01_11_00_10};
  localparam logic [479:0] OW_D = {40{12'b01_11_01_00_11_01}};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [47:0] data_a, data_b, data_c, data_d;
  logic [2:0]  pred_a, pred_b, pred_c, pred_d;
  logic        valid_a, valid_b, valid_c, valid_d;
  int          exp_a, exp_b, exp_c, exp_d;
  int          edges;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  har_tnn1_tnnzeq u_a (.clk(clk), .rst(rst), .data(data_a), .prediction(pred_a)
`ifdef TNN_VALID_EN
    , .valid(valid_a)
`endif
  );
  har_tnn1_tnnzeq #(.HIDDEN_W(HW_B), .OUT_W(OW_B)) u_b (.clk(clk), .rst(rst),
    .data(data_b), .prediction(pred_b)
`ifdef TNN_VALID_EN
    , .valid(valid_b)
`endif
  );
  har_tnn1_tnnzeq #(.HIDDEN_W(HW_C), .OUT_W(OW_C)) u_c (.clk(clk), .rst(rst),
    .data(data_c), .prediction(pred_c)
`ifdef TNN_VALID_EN
    , .valid(valid_c)
`endif
  );
  har_tnn1_tnnzeq #(.HIDDEN_W(HW_D), .OUT_W(OW_D)) u_d (.clk(clk), .rst(rst),
    .data(data_d), .prediction(pred_d)
`ifdef TNN_VALID_EN
    , .valid(valid_d)
`endif
  );

`ifndef TNN_VALID_EN
  assign valid_a = 1'b0;
  assign valid_b = 1'b0;
  assign valid_c = 1'b0;
  assign valid_d = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t, edge %0d)", name, act, exp, $time, edges);
    end
  endtask

  function automatic int wval(input logic [1:0] w);
    if (w == 2'b01) return 1;
    if (w == 2'b11) return -1;
    return 0;
  endfunction

  // Reference: full dot products computed directly, then argmax with lowest-index ties.
  function automatic int model_pred(input logic [959:0] hw, input logic [479:0] ow,
                                    input logic [47:0] d);
    int acc;
    int score [6];
    bit hid [40];
    int best;
    for (int j = 0; j < 40; j++) begin
      acc = 0;
      for (int i = 0; i < 12; i++) acc += wval(hw[2*(j*12+i) +: 2]) * int'(d[4*i +: 4]);
      hid[j] = (acc >= 0);
    end
    for (int k = 0; k < 6; k++) begin
      score[k] = 0;
      for (int j = 0; j < 40; j++) if (hid[j]) score[k] += wval(ow[2*(k*40+j) +: 2]);
    end
    best = 0;
    for (int k = 1; k < 6; k++) if (score[k] > score[best]) best = k;
    return best;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) edges <= 0;
    else      edges <= edges + 1;
  end

  // Every cycle: prediction is 0 until LAT edges after release, then the model's class.
  always @(negedge clk) begin
    bit done;
    done = rst && (edges >= LAT);
    check("pred_a", 32'(pred_a), done ? exp_a : 0);
    check("pred_b", 32'(pred_b), done ? exp_b : 0);
    check("pred_c", 32'(pred_c), done ? exp_c : 0);
    check("pred_d", 32'(pred_d), done ? exp_d : 0);
`ifdef TNN_VALID_EN
    check("valid_a", 32'(valid_a), 32'(done));
    check("valid_b", 32'(valid_b), 32'(done));
    check("valid_c", 32'(valid_c), 32'(done));
    check("valid_d", 32'(valid_d), 32'(done));
`endif
  end

  task automatic set_data(input logic [47:0] a, input logic [47:0] b,
                          input logic [47:0] c, input logic [47:0] d);
    data_a = a; data_b = b; data_c = c; data_d = d;
    exp_a  = model_pred('0, '0, a);
    exp_b  = model_pred(HW_B, OW_B, b);
    exp_c  = model_pred(HW_C, OW_C, c);
    exp_d  = model_pred(HW_D, OW_D, d);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Assert reset between clock edges and confirm outputs clear without waiting for a clock.
  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    check({tag, "_async_pred_b"}, 32'(pred_b), 0);
    check({tag, "_async_pred_c"}, 32'(pred_c), 0);
`ifdef TNN_VALID_EN
    check({tag, "_async_valid_c"}, 32'(valid_c), 0);
`endif
  endtask

  task automatic literal_checks(input string tag, input int want_b);
    run_edges(LAT - 1);
    check({tag, "_c_edge51"}, 32'(pred_c), 0);
    run_edges(1);
    check({tag, "_a_edge52"}, 32'(pred_a), 0);
    check({tag, "_b_edge52"}, 32'(pred_b), want_b);
    check({tag, "_c_edge52"}, 32'(pred_c), 2);
`ifdef TNN_VALID_EN
    check({tag, "_valid_edge52"}, 32'(valid_c), 1);
`endif
    run_edges(4);
    check({tag, "_c_held"}, 32'(pred_c), 2);
  endtask

  initial begin
    set_data(48'h9C3_5A7_1E2_F08, 48'h0, {12{4'hF}}, 48'h3A5F_0C81_7E29);
    check("model_a", exp_a, 0);
    check("model_b0", exp_b, 5);
    check("model_c", exp_c, 2);
    run_edges(3);
    check("reset_pred_c", 32'(pred_c), 0);

    release_rst();
    literal_checks("run1", 5);
    async_reset("run1");

    set_data(48'h0123_4567_89AB, {12{4'h1}}, {12{4'hF}}, 48'h0F1E_2D3C_4B5A);
    check("model_b1", exp_b, 0);
    run_edges(2);
    release_rst();
    run_edges(30);
    check("mid_pred_c", 32'(pred_c), 0);
    #2 rst = 1'b0;
    run_edges(2);
    release_rst();
    literal_checks("run2", 0);
    async_reset("run2");
    run_edges(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
